// File: rtl/fsm_seqdet_param.sv
// fsm_seqdet_param: parametrised serial sequence detector.
//
// Compares a 1-bit input stream (consumed only when en=1) against an N-bit
// PATTERN, MSB first. The state s is the length of the longest suffix of the
// consumed stream that equals a prefix of PATTERN. A mismatch falls back to
// the next shorter prefix that still fits (KMP failure fallback) rather than
// straight to zero.
//
// Outputs:
//   x     - registered (Moore) match flag, high while s == N
//   y     - combinational (Mealy) match flag, en & (next s == N)
//   count - saturating number of matches since reset
//   s     - current state, for debug
//
// The full next-state table is computed at elaboration time from N, PATTERN
// and OVERLAP. The pattern cannot be loaded at run time.
//
// Optional build macro: FSM_SEQDET_CLR_EN
//   When defined, adds the input port clr (placed after reset). clr=1 zeroes
//   count on the next clk edge and takes priority over an increment. s, x and
//   y are not affected by clr.
//
// Structure:
//   fsm_seqdet_param_nsl  - next-state / Mealy output logic (combinational)
//   fsm_seqdet_param_regs - state, Moore flag and counter registers
//   fsm_seqdet_param      - top level, wires the two together

// ---------------------------------------------------------------------------
// Next-state and Mealy output logic.
// ---------------------------------------------------------------------------
module fsm_seqdet_param_nsl #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           SW      = $clog2(N + 1)
) (
    input  logic          i_en,
    input  logic          i_a,
    input  logic [SW-1:0] i_s,
    output logic [SW-1:0] o_s_upd,
    output logic          o_y
);

    localparam int            NST    = 1 << SW;
    localparam logic [SW-1:0] S_FULL = SW'(N);

    // Next state for the given current state and input bit.
    //
    // The history is rebuilt from the state alone, because state k means
    // the last k bits were PATTERN[N-1 -: k]. The input bit is appended as
    // the LSB. The result is the longest suffix of that history that is also
    // a prefix of PATTERN.
    //
    // Encodings above N are unreachable, so they map to 0.
    function automatic int kmp_next(input int st, input int bit_in);
        int pat;
        int hist;
        int hlen;
        int lim;
        int res;
        pat  = 32'(PATTERN);
        res  = 0;
        hist = 0;
        hlen = 0;
        if (st >= 0 && st <= N) begin
            if (st == N && !OVERLAP) begin
                // Non-overlapping: after a full match, the detector starts
                // again from the new bit alone.
                hist = bit_in & 1;
                hlen = 1;
            end else begin
                hist = ((pat >> (N - st)) << 1) | (bit_in & 1);
                hlen = st + 1;
            end
            lim = (hlen < N) ? hlen : N;
            // Search from the longest candidate down; keep the first hit.
            for (int k = N; k >= 1; k--) begin
                if (res == 0 && k <= lim &&
                    ((hist & ((1 << k) - 1)) == (pat >> (N - k)))) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

    logic [SW-1:0] w_ns_a0 [NST];
    logic [SW-1:0] w_ns_a1 [NST];
    logic          w_valid [NST];

    // Elaboration-time next-state table: one entry per encoding and input bit.
    genvar gi;
    generate
        for (gi = 0; gi < NST; gi++) begin : g_tbl
            localparam int NS0 = kmp_next(gi, 0);
            localparam int NS1 = kmp_next(gi, 1);
            assign w_ns_a0[gi] = SW'(NS0);
            assign w_ns_a1[gi] = SW'(NS1);
            assign w_valid[gi] = (gi <= N) ? 1'b1 : 1'b0;
        end
    endgenerate

    logic [SW-1:0] w_step;

    // Select the table entry and apply the hold / scrub rules.
    always_comb begin
        w_step = i_a ? w_ns_a1[i_s] : w_ns_a0[i_s];
        if (!w_valid[i_s]) begin
            // An illegal encoding returns to empty whether or not en is set.
            o_s_upd = '0;
        end else if (i_en) begin
            o_s_upd = w_step;
        end else begin
            o_s_upd = i_s;
        end
        o_y = i_en & (w_step == S_FULL);
    end

endmodule

// ---------------------------------------------------------------------------
// State, Moore flag and saturating match counter registers.
// ---------------------------------------------------------------------------
module fsm_seqdet_param_regs #(
    parameter int N  = 4,
    parameter int SW = $clog2(N + 1),
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_clr,
    input  logic [SW-1:0] i_s_upd,
    input  logic          i_hit,
    output logic [SW-1:0] o_s,
    output logic          o_x,
    output logic [CW-1:0] o_count
);

    localparam logic [SW-1:0] S_FULL  = SW'(N);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [SW-1:0] r_s;
    logic          r_x;
    logic [CW-1:0] r_count;

    // Register the state. x is registered from the same update, so it is
    // high exactly while s == N. The counter stops at its maximum value
    // rather than wrapping.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_s     <= '0;
            r_x     <= 1'b0;
            r_count <= '0;
        end else begin
            r_s <= i_s_upd;
            r_x <= (i_s_upd == S_FULL);
            if (i_clr) begin
                r_count <= '0;
            end else if (i_hit && (r_count != CNT_MAX)) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_s     = r_s;
    assign o_x     = r_x;
    assign o_count = r_count;

endmodule

// ---------------------------------------------------------------------------
// Top level.
// ---------------------------------------------------------------------------
module fsm_seqdet_param #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CW      = 8,
    localparam int          SW      = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
`ifdef FSM_SEQDET_CLR_EN
    input  logic          clr,
`endif
    input  logic          en,
    input  logic          a,
    output logic          x,
    output logic          y,
    output logic [CW-1:0] count,
    output logic [SW-1:0] s
);

    logic [SW-1:0] w_s;
    logic [SW-1:0] w_s_upd;
    logic          w_y;
    logic          w_clr;

`ifdef FSM_SEQDET_CLR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    fsm_seqdet_param_nsl #(
        .N       (N),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .SW      (SW)
    ) u_nsl (
        .i_en    (en),
        .i_a     (a),
        .i_s     (w_s),
        .o_s_upd (w_s_upd),
        .o_y     (w_y)
    );

    fsm_seqdet_param_regs #(
        .N  (N),
        .SW (SW),
        .CW (CW)
    ) u_regs (
        .clk     (clk),
        .i_reset (reset),
        .i_clr   (w_clr),
        .i_s_upd (w_s_upd),
        .i_hit   (w_y),
        .o_s     (w_s),
        .o_x     (x),
        .o_count (count)
    );

    assign y = w_y;
    assign s = w_s;

endmodule

// File: tb/tb_fsm_seqdet_param.sv
// Testbench for fsm_seqdet_param.
//
// Four detector instances share one stimulus stream:
//   0: 1011,   overlapping,     CW=8
//   1: 1011,   non-overlapping, CW=8
//   2: 1011,   non-overlapping, CW=2  (counter saturation)
//   3: 110110, overlapping,     CW=3  (period-3 pattern)
//
// The reference model keeps the raw stream consumed since the last restart.
// Its state is the longest suffix of that stream which equals a prefix of
// the pattern.
module tb_fsm_seqdet_param;

    localparam int NI = 4;
    localparam int P_N   [NI] = '{4, 4, 4, 6};
    localparam int P_PAT [NI] = '{11, 11, 11, 54};
    localparam bit P_OV  [NI] = '{1'b1, 1'b0, 1'b0, 1'b1};
    localparam int P_CW  [NI] = '{8, 8, 2, 3};
`ifdef FSM_SEQDET_CLR_EN
    localparam bit CLR_ON = 1'b1;
`else
    localparam bit CLR_ON = 1'b0;
`endif

    logic       clk, reset, clr, en, a;
    logic       x0, x1, x2, x3, y0, y1, y2, y3;
    logic [2:0] s0, s1, s2, s3;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic [2:0] c3;

    fsm_seqdet_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CW(8)) u_ov (
        .clk(clk), .reset(reset),
`ifdef FSM_SEQDET_CLR_EN
        .clr(clr),
`endif
        .en(en), .a(a), .x(x0), .y(y0), .count(c0), .s(s0));

    fsm_seqdet_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CW(8)) u_no (
        .clk(clk), .reset(reset),
`ifdef FSM_SEQDET_CLR_EN
        .clr(clr),
`endif
        .en(en), .a(a), .x(x1), .y(y1), .count(c1), .s(s1));

    fsm_seqdet_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CW(2)) u_sat (
        .clk(clk), .reset(reset),
`ifdef FSM_SEQDET_CLR_EN
        .clr(clr),
`endif
        .en(en), .a(a), .x(x2), .y(y2), .count(c2), .s(s2));

    fsm_seqdet_param #(.N(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .CW(3)) u_p6 (
        .clk(clk), .reset(reset),
`ifdef FSM_SEQDET_CLR_EN
        .clr(clr),
`endif
        .en(en), .a(a), .x(x3), .y(y3), .count(c3), .s(s3));

    logic [7:0] d_s [NI];
    logic [7:0] d_c [NI];
    logic       d_x [NI];
    logic       d_y [NI];
    assign d_s[0] = {5'd0, s0};
    assign d_s[1] = {5'd0, s1};
    assign d_s[2] = {5'd0, s2};
    assign d_s[3] = {5'd0, s3};
    assign d_c[0] = c0;
    assign d_c[1] = c1;
    assign d_c[2] = {6'd0, c2};
    assign d_c[3] = {5'd0, c3};
    assign d_x[0] = x0;
    assign d_x[1] = x1;
    assign d_x[2] = x2;
    assign d_x[3] = x3;
    assign d_y[0] = y0;
    assign d_y[1] = y1;
    assign d_y[2] = y2;
    assign d_y[3] = y3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit [31:0] m_hist [NI];
    int        m_len  [NI];
    int        m_s    [NI];
    int        m_cnt  [NI];
    logic      last_y [NI];

    task automatic chk(input string name, input int inst,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", name, inst, $time, got, exp);
        end
    endtask

    // Longest k <= min(len, n) such that the last k stream bits equal the
    // first k pattern bits.
    function automatic int match_len(input bit [31:0] h, input int len,
                                     input int n, input int pat);
        int best;
        best = 0;
        for (int k = 1; k <= n; k++) begin
            if (k <= len && ((h & ((32'd1 << k) - 32'd1)) == (32'(pat) >> (n - k))))
                best = k;
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_hist[i] = '0;
            m_len[i]  = 0;
            m_s[i]    = 0;
            m_cnt[i]  = 0;
        end
    endtask

    // Drive one cycle on the falling edge. Check every instance against the
    // model before the rising edge, then advance the model and return 1 ns
    // after that edge.
    task automatic apply(input bit rst, input bit e, input bit av, input bit c);
        bit [31:0] nh [NI];
        int        nl [NI];
        int        ns [NI];
        @(negedge clk);
        reset = rst;
        en    = e;
        a     = av;
        clr   = c;
        #1;
        for (int i = 0; i < NI; i++) begin
            if (!P_OV[i] && m_s[i] == P_N[i]) begin
                nh[i] = {31'd0, av};
                nl[i] = 1;
            end else begin
                nh[i] = {m_hist[i][30:0], av};
                nl[i] = (m_len[i] < 32) ? m_len[i] + 1 : 32;
            end
            ns[i] = match_len(nh[i], nl[i], P_N[i], P_PAT[i]);
            chk("y", i, {31'd0, d_y[i]}, {31'd0, (e && ns[i] == P_N[i])});
            chk("s", i, {24'd0, d_s[i]}, m_s[i]);
            chk("x", i, {31'd0, d_x[i]}, {31'd0, (m_s[i] == P_N[i])});
            chk("count", i, {24'd0, d_c[i]}, m_cnt[i]);
            last_y[i] = d_y[i];
        end
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (e) begin
                    m_hist[i] = nh[i];
                    m_len[i]  = nl[i];
                    m_s[i]    = ns[i];
                    if (ns[i] == P_N[i] && m_cnt[i] < (1 << P_CW[i]) - 1)
                        m_cnt[i] = m_cnt[i] + 1;
                end
                if (c && CLR_ON) m_cnt[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: stimulus plus expected values for instances 0 and 1.
    // y is sampled during the cycle; s and count are checked after the edge.
    typedef struct {
        bit rst;
        bit en;
        bit a;
        int y0, s0, c0;
        int y1, s1, c1;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit e, input bit av,
                                input int ya, input int sa, input int ca,
                                input int yb, input int sb, input int cb);
        vec_t v;
        v.rst = r; v.en = e; v.a = av;
        v.y0 = ya; v.s0 = sa; v.c0 = ca;
        v.y1 = yb; v.s1 = sb; v.c1 = cb;
        tbl.push_back(v);
    endfunction

    initial begin
        int sat_exp [5] = '{1, 2, 3, 3, 3};
        int pulses;
        bit b1011 [4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit b110 [3]    = '{1'b1, 1'b1, 1'b0};

        // Reset toggling a/en
        add(1,1,1, 0,0,0, 0,0,0);
        add(1,0,0, 0,0,0, 0,0,0);
        // Stream 1,0,1,1,0,1,1
        add(0,1,1, 0,1,0, 0,1,0);
        add(0,1,0, 0,2,0, 0,2,0);
        add(0,1,1, 0,3,0, 0,3,0);
        add(0,1,1, 1,4,1, 1,4,1);
        add(0,1,0, 0,2,1, 0,0,1);
        add(0,1,1, 0,3,1, 0,1,1);
        add(0,1,1, 1,4,2, 0,1,1);
        add(1,0,0, 0,0,0, 0,0,0);
        // Fallback with idle cycles: 1,1,-,-,0,1,-,-,1
        add(0,1,1, 0,1,0, 0,1,0);
        add(0,1,1, 0,1,0, 0,1,0);
        add(0,0,0, 0,1,0, 0,1,0);
        add(0,0,1, 0,1,0, 0,1,0);
        add(0,1,0, 0,2,0, 0,2,0);
        add(0,1,1, 0,3,0, 0,3,0);
        add(0,0,0, 0,3,0, 0,3,0);
        add(0,0,1, 0,3,0, 0,3,0);
        add(0,1,1, 1,4,1, 1,4,1);
        add(0,0,0, 0,4,1, 0,4,1);
        add(0,1,0, 0,2,1, 0,0,1);
        // Reset mid-pattern (y still follows its equation during reset)
        add(1,0,1, 0,0,0, 0,0,0);
        add(0,1,1, 0,1,0, 0,1,0);
        add(0,1,0, 0,2,0, 0,2,0);
        add(0,1,1, 0,3,0, 0,3,0);
        add(1,1,1, 1,0,0, 1,0,0);
        add(0,1,1, 0,1,0, 0,1,0);
        add(0,1,0, 0,2,0, 0,2,0);
        add(0,1,1, 0,3,0, 0,3,0);
        add(0,1,1, 1,4,1, 1,4,1);

        // Unchecked power-up reset
        reset = 1'b1; en = 1'b0; a = 1'b0; clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].a, 1'b0);
            chk("tbl_y0", 0, {31'd0, last_y[0]}, tbl[i].y0);
            chk("tbl_s0", 0, {24'd0, d_s[0]}, tbl[i].s0);
            chk("tbl_x0", 0, {31'd0, d_x[0]}, {31'd0, (tbl[i].s0 == 4)});
            chk("tbl_c0", 0, {24'd0, d_c[0]}, tbl[i].c0);
            chk("tbl_y1", 1, {31'd0, last_y[1]}, tbl[i].y1);
            chk("tbl_s1", 1, {24'd0, d_s[1]}, tbl[i].s1);
            chk("tbl_c1", 1, {24'd0, d_c[1]}, tbl[i].c1);
        end

        // Saturation on the CW=2 instance: five non-overlapping matches
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            for (int b = 0; b < 4; b++) begin
                apply(1'b0, 1'b1, b1011[b], 1'b0);
                pulses += int'(last_y[2]);
            end
            chk("sat_count", 2, {24'd0, d_c[2]}, sat_exp[r]);
        end
        chk("sat_pulses", 2, pulses, 5);

        // Back-to-back matches on the period-3 pattern 110110
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 3; b++) begin
                apply(1'b0, 1'b1, b110[b], 1'b0);
                pulses += int'(last_y[3]);
            end
        end
        chk("p6_pulses", 3, pulses, 2);
        chk("p6_count", 3, {24'd0, d_c[3]}, 2);
        chk("p6_x", 3, {31'd0, d_x[3]}, 1);

`ifdef FSM_SEQDET_CLR_EN
        // clr coincident with the matching bit
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_y", 0, {31'd0, last_y[0]}, 1);
        chk("clr_count", 0, {24'd0, d_c[0]}, 0);
        chk("clr_x", 0, {31'd0, d_x[0]}, 1);
        chk("clr_s", 0, {24'd0, d_s[0]}, 4);
`endif

        // Randomized stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            apply($urandom_range(0, 99) == 0, ($urandom % 4) != 0,
                  1'($urandom), $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
